// File: rtl/mdu_pkg.sv
// Shared MDU definitions: divider FSM states, MULT/DIV alucontrol codes,
// and iteration-counter sizing.
package mdu_pkg;

   typedef enum logic [2:0] {
      DIV_IDLE,
      DIV_PREP,
      DIV_CALC,
      DIV_FIX,
      DIV_DONE
   } div_state_t;

   localparam logic [5:0] ALU_MULT  = 6'h18;
   localparam logic [5:0] ALU_MULTU = 6'h19;
   localparam logic [5:0] ALU_DIV   = 6'h1a;
   localparam logic [5:0] ALU_DIVU  = 6'h1b;

   localparam int DIV_WIDTH = 32;
   localparam int CNT_W     = $clog2(DIV_WIDTH + 1);

   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division iteration: shift {rem,quo} left and trial-subtract.
// Pure combinational so a radix-4 build can chain two per cycle.
module mdu_div_step
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic [WIDTH-1:0] quo_next
);

   logic [WIDTH:0]   shifted;
   logic [WIDTH+1:0] diff;
   logic             unused_msb;

   assign shifted = {rem, quo[WIDTH-1]};
   assign diff    = {1'b0, shifted} - {2'b00, divisor};

   // rem < divisor always holds, so a kept difference fits in WIDTH bits
   assign unused_msb = diff[WIDTH];

   always_comb begin
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
      if (!diff[WIDTH+1]) begin
         rem_next = diff[WIDTH-1:0];
         quo_next = {quo[WIDTH-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/mdu_div.sv
// Iterative restoring divider behind the EXE div_start/div_ready handshake.
// Signed/unsigned per request, divide-by-zero early-out, cancel on flush.
module mdu_div
   import mdu_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter bit ZERO_EARLY = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             signed_i,
   input  logic             cancel_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic             busy_o,
   output logic             ready_o,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o,
   output logic             div_zero_o
);

   localparam int CW = cnt_width(WIDTH);

   div_state_t       state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             sgn;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvs;
   logic             neg_q;
   logic             neg_r;
   logic             dz;
   logic [WIDTH-1:0] rem_nx;
   logic [WIDTH-1:0] quo_nx;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;

   // magnitude of the most-negative value is exact as unsigned WIDTH
   assign a_neg = sgn & a_q[WIDTH-1];
   assign b_neg = sgn & b_q[WIDTH-1];
   assign a_mag = a_neg ? -a_q : a_q;
   assign b_mag = b_neg ? -b_q : b_q;

   mdu_div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem),
      .quo      (quo),
      .divisor  (dvs),
      .rem_next (rem_nx),
      .quo_next (quo_nx)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= DIV_IDLE;
         cnt         <= '0;
         a_q         <= '0;
         b_q         <= '0;
         sgn         <= 1'b0;
         rem         <= '0;
         quo         <= '0;
         dvs         <= '0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         dz          <= 1'b0;
         busy_o      <= 1'b0;
         ready_o     <= 1'b0;
         quotient_o  <= '0;
         remainder_o <= '0;
         div_zero_o  <= 1'b0;
      end else if (cancel_i && state != DIV_IDLE) begin
         state   <= DIV_IDLE;
         busy_o  <= 1'b0;
         ready_o <= 1'b0;
      end else begin
         unique case (state)
            DIV_IDLE: begin
               ready_o <= 1'b0;
               if (start_i && !cancel_i) begin
                  a_q    <= dividend_i;
                  b_q    <= divisor_i;
                  sgn    <= signed_i;
                  busy_o <= 1'b1;
                  state  <= DIV_PREP;
               end
            end
            DIV_PREP: begin
               rem   <= '0;
               quo   <= a_mag;
               dvs   <= b_mag;
               neg_q <= a_neg ^ b_neg;
               neg_r <= a_neg;
               dz    <= (b_q == '0);
               cnt   <= CW'(WIDTH);
               if (b_q == '0 && ZERO_EARLY) begin
                  quotient_o  <= '1;
                  remainder_o <= a_q;
                  div_zero_o  <= 1'b1;
                  ready_o     <= 1'b1;
                  state       <= DIV_DONE;
               end else begin
                  state <= DIV_CALC;
               end
            end
            DIV_CALC: begin
               rem <= rem_nx;
               quo <= quo_nx;
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) state <= DIV_FIX;
            end
            DIV_FIX: begin
               // a zero divisor reports raw operands, no sign fix
               if (dz) begin
                  quotient_o  <= '1;
                  remainder_o <= a_q;
               end else begin
                  quotient_o  <= neg_q ? -quo : quo;
                  remainder_o <= neg_r ? -rem : rem;
               end
               div_zero_o <= dz;
               ready_o    <= 1'b1;
               state      <= DIV_DONE;
            end
            DIV_DONE: begin
               ready_o <= 1'b0;
               busy_o  <= 1'b0;
               state   <= DIV_IDLE;
            end
            default: begin
               ready_o <= 1'b0;
               busy_o  <= 1'b0;
               state   <= DIV_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_div.sv
// Directed bench for mdu_div: 32-bit early-zero build and an 8-bit
// full-latency build, vector table plus cancel/reset/handshake sequences.
module tb_mdu_div;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start32 = 1'b0;
   logic        start8 = 1'b0;
   logic        sg = 1'b0;
   logic        cancel = 1'b0;
   logic [31:0] a32 = '0;
   logic [31:0] b32 = '0;
   logic [7:0]  a8 = '0;
   logic [7:0]  b8 = '0;
   logic        busy32, ready32, dz32;
   logic [31:0] q32, r32;
   logic        busy8, ready8, dz8;
   logic [7:0]  q8, r8;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   mdu_div #(.WIDTH(32), .ZERO_EARLY(1'b1)) dut32 (
      .clk         (clk),
      .rst         (rst),
      .start_i     (start32),
      .signed_i    (sg),
      .cancel_i    (cancel),
      .dividend_i  (a32),
      .divisor_i   (b32),
      .busy_o      (busy32),
      .ready_o     (ready32),
      .quotient_o  (q32),
      .remainder_o (r32),
      .div_zero_o  (dz32)
   );

   mdu_div #(.WIDTH(8), .ZERO_EARLY(1'b0)) dut8 (
      .clk         (clk),
      .rst         (rst),
      .start_i     (start8),
      .signed_i    (sg),
      .cancel_i    (cancel),
      .dividend_i  (a8),
      .divisor_i   (b8),
      .busy_o      (busy8),
      .ready_o     (ready8),
      .quotient_o  (q8),
      .remainder_o (r8),
      .div_zero_o  (dz8)
   );

   typedef struct {
      bit          w8;
      bit          sg;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      bit          dz;
      int          lat;
   } vec_t;

   localparam int NV = 13;
   vec_t v [NV];

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, got, exp);
      end
   endtask

   task automatic do_div(input bit w8, input bit s,
                         input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic dz, output int lat,
                         output int bc, output bit pulse_ok);
      int n;
      bit rdy;
      @(negedge clk);
      sg = s;
      if (w8) begin
         a8 = a[7:0];
         b8 = b[7:0];
         start8 = 1'b1;
      end else begin
         a32 = a;
         b32 = b;
         start32 = 1'b1;
      end
      @(negedge clk);
      start8 = 1'b0;
      start32 = 1'b0;
      n = 1;
      bc = 0;
      rdy = 1'b0;
      while (n < 100) begin
         rdy = w8 ? ready8 : ready32;
         if (w8 ? busy8 : busy32) bc++;
         if (rdy) break;
         @(negedge clk);
         n++;
      end
      lat = rdy ? n : -1;
      q = w8 ? {24'b0, q8} : q32;
      r = w8 ? {24'b0, r8} : r32;
      dz = w8 ? dz8 : dz32;
      @(negedge clk);
      pulse_ok = w8 ? (!ready8 && !busy8) : (!ready32 && !busy32);
   endtask

   initial begin
      logic [31:0] q, r;
      logic        dz;
      int          lat, bc, n;
      bit          ok, seen;
      logic [31:0] pq, pr;
      logic        pdz;

      v[0]  = '{1, 1, 32'h80, 32'h03, 32'hd6, 32'hfe, 0, 11};
      v[1]  = '{1, 0, 32'h08, 32'h00, 32'hff, 32'h08, 1, 11};
      v[2]  = '{1, 1, 32'h80, 32'hff, 32'h80, 32'h00, 0, 11};
      v[3]  = '{0, 0, 100, 7, 14, 2, 0, 35};
      v[4]  = '{0, 1, 32'hffffff9c, 7, 32'hfffffff2,
                32'hfffffffe, 0, 35};
      v[5]  = '{0, 1, 100, 32'hfffffff9, 32'hfffffff2, 2, 0, 35};
      v[6]  = '{0, 1, 32'h80000000, 32'hffffffff,
                32'h80000000, 0, 0, 35};
      v[7]  = '{0, 0, 32'h80000000, 32'hffffffff,
                0, 32'h80000000, 0, 35};
      v[8]  = '{0, 0, 1234, 0, 32'hffffffff, 1234, 1, 2};
      v[9]  = '{0, 1, 32'hfffffffb, 0, 32'hffffffff,
                32'hfffffffb, 1, 2};
      v[10] = '{0, 0, 32'hffffffff, 1, 32'hffffffff, 0, 0, 35};
      v[11] = '{0, 0, 7, 100, 0, 7, 0, 35};
      v[12] = '{0, 1, 32'hffffff9c, 32'hfffffff9, 14,
                32'hfffffffe, 0, 35};

      repeat (2) @(negedge clk);
      chk("rst_busy32", busy32, 0);
      chk("rst_ready32", ready32, 0);
      chk("rst_q32", q32, 0);
      chk("rst_r32", r32, 0);
      chk("rst_dz32", dz32, 0);
      chk("rst_busy8", busy8, 0);
      chk("rst_q8", q8, 0);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         do_div(v[i].w8, v[i].sg, v[i].a, v[i].b, q, r, dz, lat, bc, ok);
         chk($sformatf("v%0d_lat", i), lat, v[i].lat);
         chk($sformatf("v%0d_busy", i), bc, v[i].lat);
         chk($sformatf("v%0d_q", i), q, v[i].q);
         chk($sformatf("v%0d_r", i), r, v[i].r);
         chk($sformatf("v%0d_dz", i), dz, v[i].dz);
         chk($sformatf("v%0d_pulse", i), ok, 1);
      end
      pq = v[NV-1].q;
      pr = v[NV-1].r;
      pdz = v[NV-1].dz;

      // cancel mid-CALC: no ready, outputs hold
      @(negedge clk);
      sg = 1'b0;
      a32 = 1000;
      b32 = 3;
      start32 = 1'b1;
      @(negedge clk);
      start32 = 1'b0;
      repeat (9) @(negedge clk);
      chk("cx_busy_t10", busy32, 1);
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
      seen = ready32;
      @(negedge clk);
      chk("cx_busy_t12", busy32, 0);
      for (int k = 0; k < 40; k++) begin
         if (ready32 || busy32) seen = 1'b1;
         @(negedge clk);
      end
      chk("cx_no_ready", seen, 0);
      chk("cx_q_hold", q32, pq);
      chk("cx_r_hold", r32, pr);
      chk("cx_dz_hold", dz32, pdz);

      do_div(0, 0, 9, 2, q, r, dz, lat, bc, ok);
      chk("after_cx_q", q, 4);
      chk("after_cx_r", r, 1);
      chk("after_cx_lat", lat, 35);

      // start together with cancel in IDLE is rejected
      @(negedge clk);
      a32 = 50;
      b32 = 5;
      start32 = 1'b1;
      cancel = 1'b1;
      @(negedge clk);
      start32 = 1'b0;
      cancel = 1'b0;
      chk("rej_busy0", busy32, 0);
      @(negedge clk);
      chk("rej_busy1", busy32, 0);

      // start while in DONE is ignored
      @(negedge clk);
      a32 = 20;
      b32 = 6;
      start32 = 1'b1;
      @(negedge clk);
      start32 = 1'b0;
      n = 1;
      while (!ready32 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("done_lat", ready32 ? n : -1, 35);
      a32 = 50;
      b32 = 5;
      start32 = 1'b1;
      @(negedge clk);
      start32 = 1'b0;
      chk("done_start_ign", busy32, 0);
      chk("done_q", q32, 3);
      chk("done_r", r32, 2);

      // reset mid-CALC
      @(negedge clk);
      a32 = 1000;
      b32 = 3;
      start32 = 1'b1;
      @(negedge clk);
      start32 = 1'b0;
      repeat (19) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mr_busy", busy32, 0);
      chk("mr_ready", ready32, 0);
      chk("mr_q", q32, 0);
      chk("mr_r", r32, 0);
      chk("mr_dz", dz32, 0);
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (ready32) seen = 1'b1;
         @(negedge clk);
      end
      chk("mr_no_ready", seen, 0);

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
